sparse_chunk_encoder: RTL and testbench
=======================================

# sparse_chunk_encoder

Synthesizable encoder that turns dense activation/weight beats into the compressed chunk write stream consumed by the IFM and filter SRAM write ports. Each chunk of `MEM_SIZE` dense bytes is collected over `MEM_SIZE/BUS_SIZE` input beats. The block then emits, per output beat:
- a sparsemap slice with one bit per byte;
- a slice of the chunk-wide packed nonzero byte array.

It sits directly upstream of the buffer write interface, replacing random stimulus generation with real data.

## Interface
- `MEM_SIZE`, default `` `MEM_SIZE ``: bytes per chunk.
- `BUS_SIZE`, default `` `BUS_SIZE ``: bytes per beat; must divide `MEM_SIZE`.
- `CHUNK_NUM`, default `` `MEM_SIZE/`CHANNEL_NUM ``: chunks per frame; sets the wrap point of `chunk_count_o`.
- `CHANNEL_NUM`, default `` `CHANNEL_NUM ``: valid channels per chunk; used only under the macro.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-low.
- `in_data_i`, in, `BUS_SIZE*8`: dense beat; byte i is bits `[8i+7:8i]`.
- `in_valid_i`, in, 1: input beat valid.
- `in_ready_o`, out, 1: block accepts a beat.
- `wr_sparsemap_o`, out, `BUS_SIZE`: bit i is 1 iff chunk byte `dat_count*BUS_SIZE+i` is nonzero.
- `wr_nonzero_data_o`, out, `BUS_SIZE*8`: packed nonzero bytes `[dat_count*BUS_SIZE +: BUS_SIZE]`.
- `wr_valid_o`, out, 1: output beat valid. No backpressure.
- `wr_dat_count_o`, out, `$clog2(MEM_SIZE/BUS_SIZE)`: beat index within the chunk.
- `wr_chunk_count_o`, out, `$clog2(CHUNK_NUM)`: chunk index.
- `frame_done_o`, out, 1: one-cycle pulse after the last beat of chunk `CHUNK_NUM-1`.

## Operation
- **FSM states:**
  - `COLLECT`: `in_ready_o=1`. Each accepted beat ORs its sparsemap slice into the chunk map. Its nonzero bytes are compacted in ascending byte order and written to the chunk data buffer at `nnz_cnt`; `nnz_cnt` advances by the beat popcount. After beat `BEATS-1` is accepted, go to `DRAIN`.
  - `DRAIN`: `in_ready_o=0` and `wr_valid_o=1` for `BEATS` consecutive cycles, with `wr_dat_count_o` running 0..`BEATS-1`. After the last beat, clear `nnz_cnt` and the map, increment `wr_chunk_count_o` (wrap `CHUNK_NUM-1`→0), and return to `COLLECT`.
- **Output masking:** packed bytes with index ≥ `nnz_cnt` are driven as 0x00 via a compare mask, not by clearing the buffer.
- **Widths:**
  - `BEATS = MEM_SIZE/BUS_SIZE`.
  - `nnz_cnt` is `$clog2(MEM_SIZE+1)` bits.
  - Per-beat popcount is `$clog2(BUS_SIZE+1)` bits.
- **Gaps:** input gaps (`in_valid_i=0`) simply stall `COLLECT`. The accepted beat count is the only chunk delimiter.
- **Reset mid-operation:** any partial chunk or drain is discarded; the FSM returns to `COLLECT` with beat 0 and chunk 0.

## Timing
- **Reset values:**
  - `in_ready_o` = 0 during reset, 1 in the first cycle after it.
  - `wr_valid_o`, `wr_sparsemap_o`, `wr_nonzero_data_o`, `wr_dat_count_o`, `wr_chunk_count_o`, `frame_done_o` = 0.
- **Latency:** output beat 0 is registered and appears in the cycle after the last input beat of a chunk is accepted.
- **Drain:**
  - Lasts exactly `BEATS` cycles.
  - `in_ready_o` rises in the cycle after the final drain beat.
  - Throughput is one chunk per `2*BEATS` cycles at best.
- **Frame done:** `frame_done_o` pulses in the cycle after the final drain beat of chunk `CHUNK_NUM-1`, concurrent with `wr_chunk_count_o` returning to 0.
- **Idle outputs:** outside `DRAIN`, `wr_valid_o=0`, data/map outputs are 0, and the counts hold.

## Configuration
- **`ENC_CHANNEL_PAD_EN` defined:** chunk bytes at index ≥ `CHANNEL_NUM` are forced to zero before encoding. Their sparsemap bits are 0 and they never enter the packed array.
- **`ENC_CHANNEL_PAD_EN` undefined:** all `MEM_SIZE` bytes are encoded as received, and `CHANNEL_NUM` is unused.

## Structure
- **Shared package `sparse_enc_pkg`:**
  - FSM state enum `enc_state_e` (`COLLECT`, `DRAIN`).
  - Localparams `BEATS`, `NNZ_W`, `DAT_CNT_W`.
- **Sub-module `sparse_beat_compactor`:** combinational. Takes one dense beat and produces:
  - a `BUS_SIZE`-bit map;
  - a prefix-sum-compacted byte vector;
  - the popcount.

## Test plan
Parameters for all scenarios: `BUS_SIZE=32`, `MEM_SIZE=128` (BEATS=4), `CHUNK_NUM=2`.
1. **All-zero chunk:** 4 zero beats → 4 drain beats with map=0, data=0, `dat_count` 0,1,2,3, `chunk_count`=0.
2. **All bytes 0x01:** → every map beat is all-ones and every data beat is all 0x01.
3. **Single nonzero byte:** only byte 0 of input beat 3 = 0xAB → data beat 0 byte 0 = 0xAB and all other data bytes 0; map beat 3 = 0x00000001, other map beats 0.
4. **Valid gaps:** `in_valid_i` toggled every cycle on scenario 3's data → identical output; `in_ready_o` low exactly 4 cycles during drain.
5. **Two chunks back to back:** → `chunk_count` 0 then 1; `frame_done_o` pulses once after the second drain; the next chunk reports `chunk_count`=0.
6. **Reset mid-chunk:** `rst_i=0` after 2 accepted beats → no output beats, all outputs 0; the next 4 beats drain as `chunk_count`=0. With `ENC_CHANNEL_PAD_EN` and `CHANNEL_NUM=40`, all-0xFF input gives map beat 1 = 0x000000FF, and map beats 2-3 = 0.

Source files
------------

// File: rtl/sparse_enc_pkg.sv
// Shared sizing and FSM state type for the sparse chunk encoder.
// Optional build macro ENC_CHANNEL_PAD_EN is consumed by sparse_chunk_encoder.
`ifndef MEM_SIZE
`define MEM_SIZE 128
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 32
`endif
`ifndef CHANNEL_NUM
`define CHANNEL_NUM 64
`endif

package sparse_enc_pkg;

  localparam int MEM_SIZE_DEF    = `MEM_SIZE;
  localparam int BUS_SIZE_DEF    = `BUS_SIZE;
  localparam int CHANNEL_NUM_DEF = `CHANNEL_NUM;

  localparam int BEATS     = MEM_SIZE_DEF / BUS_SIZE_DEF;
  localparam int NNZ_W     = $clog2(MEM_SIZE_DEF + 1);
  localparam int DAT_CNT_W = $clog2(BEATS);

  typedef enum logic {
    COLLECT,
    DRAIN
  } enc_state_e;

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational per-beat encoder: nonzero map, nonzero bytes packed toward byte 0, popcount.
module sparse_beat_compactor
  import sparse_enc_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input  logic [BUS_SIZE*8-1:0]        beat,
  output logic [BUS_SIZE-1:0]          map,
  output logic [BUS_SIZE*8-1:0]        packed_bytes,
  output logic [$clog2(BUS_SIZE+1)-1:0] popcount
);

  localparam int PC_W = $clog2(BUS_SIZE + 1);

  // Running slot index acts as the prefix sum of nonzero bytes seen so far.
  always_comb begin
    int slot;
    map          = '0;
    packed_bytes = '0;
    slot         = 0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (beat[i*8 +: 8] != 8'h00) begin
        map[i]                     = 1'b1;
        packed_bytes[slot*8 +: 8]  = beat[i*8 +: 8];
        slot                       = slot + 1;
      end
    end
    popcount = PC_W'(slot);
  end

endmodule

// File: rtl/sparse_chunk_encoder.sv
// Collects dense beats into a chunk, then drains sparsemap + packed nonzero slices.
// Build macro ENC_CHANNEL_PAD_EN: zero chunk bytes at index >= CHANNEL_NUM before encoding.
module sparse_chunk_encoder
  import sparse_enc_pkg::*;
#(
  parameter int MEM_SIZE    = MEM_SIZE_DEF,
  parameter int BUS_SIZE    = BUS_SIZE_DEF,
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int CHUNK_NUM   = MEM_SIZE / CHANNEL_NUM
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [BUS_SIZE*8-1:0]                 in_data_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  output logic [BUS_SIZE-1:0]                   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                 wr_nonzero_data_o,
  output logic                                  wr_valid_o,
  output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]  wr_dat_count_o,
  output logic [$clog2(CHUNK_NUM)-1:0]          wr_chunk_count_o,
  output logic                                  frame_done_o
);

  localparam int NBEATS = MEM_SIZE / BUS_SIZE;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int NZ_W   = $clog2(MEM_SIZE + 1);
  localparam int PC_W   = $clog2(BUS_SIZE + 1);
  localparam int CH_W   = $clog2(CHUNK_NUM);

  enc_state_e              state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [NZ_W-1:0]         nnz_cnt, nnz_nxt;
  logic [MEM_SIZE-1:0]     map_buf, map_nxt;
  logic [MEM_SIZE*8-1:0]   data_buf, data_nxt;
  logic [BUS_SIZE*8-1:0]   beat_in;
  logic [BUS_SIZE-1:0]     beat_map;
  logic [BUS_SIZE*8-1:0]   beat_packed;
  logic [PC_W-1:0]         beat_pop;
  logic [BUS_SIZE-1:0]     map_slice;
  logic [BUS_SIZE*8-1:0]   data_slice;
  logic                    accept;

  assign in_ready_o = rst_i && (state == COLLECT);
  assign accept     = in_valid_i && in_ready_o;

`ifdef ENC_CHANNEL_PAD_EN
  always_comb begin
    beat_in = in_data_i;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (int'(beat_cnt) * BUS_SIZE + i >= CHANNEL_NUM) beat_in[i*8 +: 8] = 8'h00;
    end
  end
`else
  assign beat_in = in_data_i;
`endif

  sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .beat         (beat_in),
    .map          (beat_map),
    .packed_bytes (beat_packed),
    .popcount     (beat_pop)
  );

  // Chunk state as it will be after this cycle; lets drain beat 0 register on the last accept.
  always_comb begin
    map_nxt  = map_buf;
    data_nxt = data_buf;
    nnz_nxt  = nnz_cnt;
    if (accept) begin
      map_nxt[int'(beat_cnt)*BUS_SIZE +: BUS_SIZE] =
        map_buf[int'(beat_cnt)*BUS_SIZE +: BUS_SIZE] | beat_map;
      for (int j = 0; j < BUS_SIZE; j++) begin
        if (j < int'(beat_pop) && int'(nnz_cnt) + j < MEM_SIZE)
          data_nxt[(int'(nnz_cnt) + j)*8 +: 8] = beat_packed[j*8 +: 8];
      end
      nnz_nxt = nnz_cnt + NZ_W'(beat_pop);
    end
  end

  // Stale buffer bytes past nnz are hidden by the compare mask rather than cleared.
  always_comb begin
    int sel;
    int idx;
    sel = (state == DRAIN) ? int'(wr_dat_count_o) + 1 : 0;
    if (sel >= NBEATS) sel = 0;
    map_slice  = map_nxt[sel*BUS_SIZE +: BUS_SIZE];
    data_slice = '0;
    for (int j = 0; j < BUS_SIZE; j++) begin
      idx = sel * BUS_SIZE + j;
      if (idx < int'(nnz_nxt)) data_slice[j*8 +: 8] = data_nxt[idx*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state             <= COLLECT;
      beat_cnt          <= '0;
      nnz_cnt           <= '0;
      map_buf           <= '0;
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_dat_count_o    <= '0;
      wr_chunk_count_o  <= '0;
      frame_done_o      <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            map_buf <= map_nxt;
            nnz_cnt <= nnz_nxt;
            if (beat_cnt == CNT_W'(NBEATS - 1)) begin
              beat_cnt          <= '0;
              state             <= DRAIN;
              wr_valid_o        <= 1'b1;
              wr_dat_count_o    <= '0;
              wr_sparsemap_o    <= map_slice;
              wr_nonzero_data_o <= data_slice;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (wr_dat_count_o == CNT_W'(NBEATS - 1)) begin
            state             <= COLLECT;
            wr_valid_o        <= 1'b0;
            wr_sparsemap_o    <= '0;
            wr_nonzero_data_o <= '0;
            nnz_cnt           <= '0;
            map_buf           <= '0;
            if (wr_chunk_count_o == CH_W'(CHUNK_NUM - 1)) begin
              wr_chunk_count_o <= '0;
              frame_done_o     <= 1'b1;
            end else begin
              wr_chunk_count_o <= wr_chunk_count_o + CH_W'(1);
            end
          end else begin
            wr_dat_count_o    <= wr_dat_count_o + CNT_W'(1);
            wr_sparsemap_o    <= map_slice;
            wr_nonzero_data_o <= data_slice;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    data_buf <= data_nxt;
  end

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Directed bench: 32-byte beats, 128-byte chunks, 2 chunks per frame.
// Expected drain beats are hand-derived per scenario (pad variant under ENC_CHANNEL_PAD_EN).
module tb_sparse_chunk_encoder;

  localparam int BUS    = 32;
  localparam int MEM    = 128;
  localparam int CHUNKS = 2;
`ifdef ENC_CHANNEL_PAD_EN
  localparam int CHANNELS = 40;
`else
  localparam int CHANNELS = 64;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  wr_map;
  logic [255:0] wr_data;
  logic         wr_valid;
  logic [1:0]   wr_dat_count;
  logic [0:0]   wr_chunk_count;
  logic         frame_done;

  int total = 0;
  int bad   = 0;

  logic [255:0] stim[4];
  logic [31:0]  exp_map[4];
  logic [255:0] exp_data[4];

  sparse_chunk_encoder #(
    .MEM_SIZE   (MEM),
    .BUS_SIZE   (BUS),
    .CHANNEL_NUM(CHANNELS),
    .CHUNK_NUM  (CHUNKS)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_data_i         (in_data),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .wr_sparsemap_o    (wr_map),
    .wr_nonzero_data_o (wr_data),
    .wr_valid_o        (wr_valid),
    .wr_dat_count_o    (wr_dat_count),
    .wr_chunk_count_o  (wr_chunk_count),
    .frame_done_o      (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Feeds stim[0..3]; returns at the negedge where drain beat 0 is visible.
  task automatic applyStimulus(input bit gaps);
    for (int b = 0; b < 4; b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        checkOutput("gap_ready", 256'(in_ready), 256'(1));
      end
      for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
      checkOutput("ready_wait", 256'(in_ready), 256'(1));
      in_data  = stim[b];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic checkDrain(input int chunk, input bit frame);
    for (int d = 0; d < 4; d++) begin
      checkOutput("drain_valid", 256'(wr_valid), 256'(1));
      checkOutput("drain_ready", 256'(in_ready), 256'(0));
      checkOutput("dat_count", 256'(wr_dat_count), 256'(d));
      checkOutput("chunk_count", 256'(wr_chunk_count), 256'(chunk));
      checkOutput("map", 256'(wr_map), 256'(exp_map[d]));
      checkOutput("data", wr_data, exp_data[d]);
      checkOutput("frame_in_drain", 256'(frame_done), 256'(0));
      @(negedge clk);
    end
    checkOutput("post_valid", 256'(wr_valid), 256'(0));
    checkOutput("post_ready", 256'(in_ready), 256'(1));
    checkOutput("post_map", 256'(wr_map), 256'(0));
    checkOutput("post_data", wr_data, 256'(0));
    checkOutput("post_dat_hold", 256'(wr_dat_count), 256'(3));
    checkOutput("frame_done", 256'(frame_done), 256'(frame));
    checkOutput("post_chunk", 256'(wr_chunk_count), frame ? 256'(0) : 256'(chunk + 1));
  endtask

  task automatic clearExp();
    for (int i = 0; i < 4; i++) begin
      exp_map[i]  = '0;
      exp_data[i] = '0;
      stim[i]     = '0;
    end
  endtask

  task automatic checkIdleReset();
    checkOutput("rst_ready", 256'(in_ready), 256'(0));
    checkOutput("rst_valid", 256'(wr_valid), 256'(0));
    checkOutput("rst_map", 256'(wr_map), 256'(0));
    checkOutput("rst_data", wr_data, 256'(0));
    checkOutput("rst_dat", 256'(wr_dat_count), 256'(0));
    checkOutput("rst_chunk", 256'(wr_chunk_count), 256'(0));
    checkOutput("rst_frame", 256'(frame_done), 256'(0));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleReset();
    rst = 1'b1;
    #1;
    checkOutput("ready_after_reset", 256'(in_ready), 256'(1));

    // Scenario 1: all-zero chunk, chunk 0.
    clearExp();
    applyStimulus(1'b0);
    checkDrain(0, 1'b0);

    // Scenario 2: all bytes 0x01, chunk 1, closes the frame.
    clearExp();
    for (int i = 0; i < 4; i++) stim[i] = {32{8'h01}};
`ifdef ENC_CHANNEL_PAD_EN
    exp_map[0]  = 32'hFFFF_FFFF;
    exp_map[1]  = 32'h0000_00FF;
    exp_data[0] = {32{8'h01}};
    exp_data[1] = 256'h0101_0101_0101_0101;
`else
    for (int i = 0; i < 4; i++) begin
      exp_map[i]  = 32'hFFFF_FFFF;
      exp_data[i] = {32{8'h01}};
    end
`endif
    applyStimulus(1'b0);
    checkDrain(1, 1'b1);
    @(negedge clk);
    checkOutput("frame_one_cycle", 256'(frame_done), 256'(0));

    // Scenarios 3 and 4: single 0xAB at chunk byte 96, without and with valid gaps.
    for (int g = 0; g < 2; g++) begin
      clearExp();
      stim[3] = 256'hAB;
`ifndef ENC_CHANNEL_PAD_EN
      exp_map[3]  = 32'h0000_0001;
      exp_data[0] = 256'hAB;
`endif
      applyStimulus(g[0]);
      checkDrain(g, g == 1);
    end

    // Scenario 5: mixed chunk then zero chunk back to back; zero chunk must mask stale bytes.
    clearExp();
    stim[0] = 256'h1100;
    stim[0][255:248] = 8'h22;
    stim[2] = 256'h33;
    stim[3] = 256'h0055_4400_0000_0000;
    exp_map[0] = 32'h8000_0002;
`ifdef ENC_CHANNEL_PAD_EN
    exp_data[0] = 256'h2211;
`else
    exp_map[2]  = 32'h0000_0001;
    exp_map[3]  = 32'h0000_0060;
    exp_data[0] = 256'h55_4433_2211;
`endif
    applyStimulus(1'b0);
    checkDrain(0, 1'b0);
    clearExp();
    applyStimulus(1'b0);
    checkDrain(1, 1'b1);

    // Scenario 6: all-0xFF chunk, then a partial chunk cut by reset, then a clean chunk.
    clearExp();
    for (int i = 0; i < 4; i++) stim[i] = {32{8'hFF}};
`ifdef ENC_CHANNEL_PAD_EN
    exp_map[0]  = 32'hFFFF_FFFF;
    exp_map[1]  = 32'h0000_00FF;
    exp_data[0] = {32{8'hFF}};
    exp_data[1] = 256'hFFFF_FFFF_FFFF_FFFF;
`else
    for (int i = 0; i < 4; i++) begin
      exp_map[i]  = 32'hFFFF_FFFF;
      exp_data[i] = {32{8'hFF}};
    end
`endif
    applyStimulus(1'b0);
    checkDrain(0, 1'b0);

    in_data  = stim[0];
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    checkIdleReset();
    @(negedge clk);
    checkOutput("rst_hold_valid", 256'(wr_valid), 256'(0));
    rst = 1'b1;
    #1;
    checkOutput("ready_after_midreset", 256'(in_ready), 256'(1));
    applyStimulus(1'b0);
    checkDrain(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
